// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction
// memory, applies execute-stage redirects and feeds decode through a registered
// IF/ID output backed by a one-entry skid buffer.
module if_stage_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instruction,
  output logic               valid
);

  // REQ: a fetch is outstanding. STALL: skid is full, no request issued.
  localparam logic [0:0] StReq   = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               kill_q, kill_d;
  logic [ADDR_W-1:0]  kill_target_q, kill_target_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;

  logic               accept;
  logic               load_mem;
  logic               load_skid;

  // Decode can take a new word unless it is frozen on a live instruction.
  assign accept = !freeze || !valid_q;

  // Request is held low during reset so nothing is issued before the PC is sane.
  assign imem_req    = rst && (state_q == StReq);
  assign imem_addr   = req_addr_q;
  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign valid       = valid_q;

  // Fetch control: request address, kill bookkeeping, skid capture and state.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    kill_d        = kill_q;
    kill_target_d = kill_target_q;
    skid_instr_d  = skid_instr_q;
    skid_addr_d   = skid_addr_q;
    load_mem      = 1'b0;
    load_skid     = 1'b0;

    unique case (state_q)
      StReq: begin
        if (imem_ready) begin
          if (branch_taken || kill_q) begin
            // Returned word belongs to the wrong path; redirect, newest branch wins.
            req_addr_d = branch_taken ? branch_address : kill_target_q;
            kill_d     = 1'b0;
          end else if (accept) begin
            load_mem   = 1'b1;
            req_addr_d = req_addr_q + AddrStep;
          end else begin
            // Decode is frozen on a live word: park this one in the skid.
            skid_instr_d = imem_rdata;
            skid_addr_d  = req_addr_q;
            req_addr_d   = req_addr_q + AddrStep;
            state_d      = StStall;
          end
        end else if (branch_taken) begin
          // Address must stay stable until ready, so remember the redirect.
          kill_d        = 1'b1;
          kill_target_d = branch_address;
        end
      end
      StStall: begin
        if (branch_taken) begin
          req_addr_d = branch_address;
          state_d    = StReq;
        end else if (!freeze) begin
          load_skid = 1'b1;
          state_d   = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  // IF/ID output register: branch flush beats freeze hold beats new load.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;

    if (branch_taken) begin
      valid_d = 1'b0;
      instr_d = '0;
    end else if (freeze && valid_q) begin
      valid_d = 1'b1;
    end else if (load_mem) begin
      instr_d = imem_rdata;
      pc_d    = req_addr_q + AddrStep;
      valid_d = 1'b1;
    end else if (load_skid) begin
      instr_d = skid_instr_q;
      pc_d    = skid_addr_q + AddrStep;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Fetch-side state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StReq;
      req_addr_q    <= RESET_PC;
      kill_q        <= 1'b0;
      kill_target_q <= '0;
      skid_instr_q  <= '0;
      skid_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      kill_q        <= kill_d;
      kill_target_q <= kill_target_d;
      skid_instr_q  <= skid_instr_d;
      skid_addr_q   <= skid_addr_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Memory protocol: the request address may not move while a fetch is waiting.
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ready) |=> (imem_addr == $past(imem_addr)));

  // The skid only fills behind a live output word.
  a_stall_valid: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StStall) |-> valid_q);

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios then random traffic, checked by a
// scoreboard fed from a path-level model of the fetch stream.
module tb_if_stage_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Salt    = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  assign imem_rdata = imem_addr ^ Salt;

  if_stage_fetch #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (ResetPc)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .PC             (PC),
    .Instruction    (Instruction),
    .valid          (valid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  // Model: words fetched on the current path but not yet taken by decode.
  // The stage holds at most two (IF/ID register plus skid).
  word_t       exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_req;
  logic        redirect_pending;
  logic [31:0] redirect_target;
  logic        prev_branch;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_addr         = ResetPc;
    exp_req          = 1'b1;
    redirect_pending = 1'b0;
    redirect_target  = '0;
    prev_branch      = 1'b0;
  endtask

  // Path-level update at the end of a cycle: a fetch returns only if a request
  // was out; fetches issued before a redirect are thrown away.
  task automatic model_update();
    logic ret;
    ret = exp_req && imem_ready;
    if (branch_taken) begin
      exp_q.delete();
      if (ret || !exp_req) begin
        exp_addr         = branch_address;
        redirect_pending = 1'b0;
      end else begin
        redirect_pending = 1'b1;
        redirect_target  = branch_address;
      end
    end else if (ret) begin
      if (redirect_pending) begin
        exp_addr         = redirect_target;
        redirect_pending = 1'b0;
      end else begin
        exp_q.push_back(word_t'{pc: exp_addr + 32'd4, instr: exp_addr ^ Salt});
        exp_addr = exp_addr + 32'd4;
      end
    end
  endtask

  // One clock cycle of stimulus; requests stop only when both slots are full.
  task automatic step(input logic fz, input logic br, input logic [31:0] ba, input logic rdy);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    freeze         = fz;
    branch_taken   = br;
    branch_address = ba;
    imem_ready     = rdy;
    exp_req        = (exp_q.size() < 2);
    @(negedge clk);
    #1;
    model_update();
  endtask

  // Monitor: compare presented outputs against the scoreboard head, retire on accept.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, exp_addr);
      check("valid", 32'(valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("pc", PC, exp_q[0].pc);
        check("instr", Instruction, exp_q[0].instr);
        if (!freeze && !branch_taken) void'(exp_q.pop_front());
      end else if (prev_branch) begin
        check("instr_flush", Instruction, 32'h0);
      end
      prev_branch = branch_taken;
    end
  end

  initial begin
    rst            = 1'b0;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = '0;
    imem_ready     = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, ResetPc);
    mon_en = 1'b1;

    // Zero-wait fetch, then two wait states on address 8.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    // Freeze on a live word: next return goes to the skid, request drops.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    // Zero-wait branch.
    step(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Branch during a wait, overwritten by a second branch before ready.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h300, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Branch while stalled with a full skid.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Address wrap past the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      else ba = $urandom() & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, ba,
           $urandom_range(0, 99) < 65);
    end

    // Reset while a fetch is outstanding.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_instr", Instruction, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
